// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage RV32 pipeline: load-use bubbles,
// branch redirects and multi-cycle FPU occupancy of EX.
module pipe_stall_ctrl #(
  parameter int FPU_LAT  = 4,
  parameter int USE_DONE = 1,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             uses_rs2_id,
  input  logic [6:0]       opcode_id,
  input  logic [4:0]       rd_ex,
  input  logic             MemRd_ex,
  input  logic             RegWr_ex,
  input  logic [6:0]       opcode_ex,
  input  logic             valid_ex,
  input  logic             fpu_done,
  input  logic             br_flush,
  output logic             PC_Wr,
  output logic             IF_ID_Wr,
  output logic             ID_EX_Wr,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Bubble,
  output logic             fpu_busy,
  output logic             fpu_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_FPW = 1'b1;
  localparam logic [6:0] OP_FP = 7'b1010011;
  localparam bit         DONE_MODE = (USE_DONE != 0);
  localparam int         LAT_W = $clog2(FPU_LAT + 1);
  localparam int         TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(FPU_LAT - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  logic [0:0]       r_state;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_pend_flush;
  logic             r_fpu_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_fpu_start, w_load_use;
  logic             w_done_exit, w_to_exit, w_lat_exit, w_exit;
  logic             w_pc_wr, w_ifid_wr, w_idex_wr, w_ifid_fl, w_idex_fl, w_bub, w_busy;
  logic [0:0]       w_nxt_state;
  logic [LAT_W-1:0] w_nxt_lat;
  logic [TO_W-1:0]  w_nxt_to;
  logic             w_nxt_pend, w_set_err;

  assign w_fpu_start = valid_ex && (opcode_ex == OP_FP) && !(DONE_MODE && fpu_done);
  assign w_load_use  = MemRd_ex && RegWr_ex && (rd_ex != 5'd0) && (opcode_id != OP_FP) &&
                       ((rd_ex == rs1_id) || (uses_rs2_id && (rd_ex == rs2_id)));

  assign w_done_exit = DONE_MODE && fpu_done;
  assign w_to_exit   = DONE_MODE && (r_to_cnt == TO_LAST);
  assign w_lat_exit  = !DONE_MODE && (r_lat_cnt == '0);
  assign w_exit      = w_done_exit || w_to_exit || w_lat_exit;

  always_comb begin
    w_pc_wr     = 1'b1;
    w_ifid_wr   = 1'b1;
    w_idex_wr   = 1'b1;
    w_ifid_fl   = 1'b0;
    w_idex_fl   = 1'b0;
    w_bub       = 1'b0;
    w_busy      = 1'b0;
    w_nxt_state = r_state;
    w_nxt_lat   = r_lat_cnt;
    w_nxt_to    = r_to_cnt;
    w_nxt_pend  = r_pend_flush;
    w_set_err   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (br_flush) begin
          w_ifid_fl = 1'b1;
          w_idex_fl = 1'b1;
        end else if (w_fpu_start) begin
          w_pc_wr     = 1'b0;
          w_ifid_wr   = 1'b0;
          w_idex_wr   = 1'b0;
          w_bub       = 1'b1;
          w_nxt_state = S_FPW;
          w_nxt_lat   = LAT_INIT;
          w_nxt_to    = '0;
        end else if (w_load_use) begin
          w_pc_wr   = 1'b0;
          w_ifid_wr = 1'b0;
          w_idex_fl = 1'b1;
        end
      end
      default: begin
        if (w_exit) begin
          // A redirect seen during the hold is released together with the result.
          w_ifid_fl   = r_pend_flush || br_flush;
          w_idex_fl   = r_pend_flush || br_flush;
          w_nxt_pend  = 1'b0;
          w_nxt_state = S_RUN;
          if (w_to_exit && !w_done_exit) begin
            w_bub     = 1'b1;
            w_set_err = 1'b1;
          end
        end else begin
          w_pc_wr    = 1'b0;
          w_ifid_wr  = 1'b0;
          w_idex_wr  = 1'b0;
          w_bub      = 1'b1;
          w_busy     = 1'b1;
          w_nxt_lat  = (r_lat_cnt == '0) ? r_lat_cnt : r_lat_cnt - 1'b1;
          w_nxt_to   = r_to_cnt + 1'b1;
          w_nxt_pend = r_pend_flush || br_flush;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_lat_cnt    <= '0;
      r_to_cnt     <= '0;
      r_pend_flush <= 1'b0;
      r_fpu_err    <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_lat_cnt    <= w_nxt_lat;
      r_to_cnt     <= w_nxt_to;
      r_pend_flush <= w_nxt_pend;
      r_fpu_err    <= r_fpu_err || w_set_err;
      if (!w_pc_wr && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign PC_Wr         = rst || w_pc_wr;
  assign IF_ID_Wr      = rst || w_ifid_wr;
  assign ID_EX_Wr      = rst || w_idex_wr;
  assign IF_ID_Flush   = !rst && w_ifid_fl;
  assign ID_EX_Flush   = !rst && w_idex_fl;
  assign EX_MEM_Bubble = !rst && w_bub;
  assign fpu_busy      = !rst && w_busy;
  assign fpu_err       = !rst && r_fpu_err;
  assign stall_cnt     = rst ? '0 : r_stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a fixed-latency instance (a) and a
// done-signalled instance with short timeout (b) share one stimulus bus.
module tb_pipe_stall_ctrl;

  localparam logic [6:0] OP_FP  = 7'b1010011;
  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  // {PC_Wr, IF_ID_Wr, ID_EX_Wr, IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble}
  localparam logic [5:0] RUNV = 6'b111000;
  localparam logic [5:0] STL  = 6'b000001;
  localparam logic [5:0] LU   = 6'b001010;
  localparam logic [5:0] BRF  = 6'b111110;
  localparam logic [5:0] TOX  = 6'b111001;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic uses_rs2_id, MemRd_ex, RegWr_ex, valid_ex, fpu_done, br_flush;
  logic [6:0] opcode_id, opcode_ex;

  logic PC_Wr_a, IF_ID_Wr_a, ID_EX_Wr_a, IF_ID_Flush_a, ID_EX_Flush_a, EX_MEM_Bubble_a;
  logic fpu_busy_a, fpu_err_a;
  logic [3:0] stall_cnt_a;
  logic PC_Wr_b, IF_ID_Wr_b, ID_EX_Wr_b, IF_ID_Flush_b, ID_EX_Flush_b, EX_MEM_Bubble_b;
  logic fpu_busy_b, fpu_err_b;
  logic [31:0] stall_cnt_b;
  logic [5:0] ctl_a, ctl_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.FPU_LAT(4), .USE_DONE(0), .TIMEOUT(64), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs2_id(uses_rs2_id),
    .opcode_id(opcode_id), .rd_ex(rd_ex), .MemRd_ex(MemRd_ex), .RegWr_ex(RegWr_ex),
    .opcode_ex(opcode_ex), .valid_ex(valid_ex), .fpu_done(fpu_done), .br_flush(br_flush),
    .PC_Wr(PC_Wr_a), .IF_ID_Wr(IF_ID_Wr_a), .ID_EX_Wr(ID_EX_Wr_a),
    .IF_ID_Flush(IF_ID_Flush_a), .ID_EX_Flush(ID_EX_Flush_a), .EX_MEM_Bubble(EX_MEM_Bubble_a),
    .fpu_busy(fpu_busy_a), .fpu_err(fpu_err_a), .stall_cnt(stall_cnt_a));

  pipe_stall_ctrl #(.FPU_LAT(4), .USE_DONE(1), .TIMEOUT(8), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs2_id(uses_rs2_id),
    .opcode_id(opcode_id), .rd_ex(rd_ex), .MemRd_ex(MemRd_ex), .RegWr_ex(RegWr_ex),
    .opcode_ex(opcode_ex), .valid_ex(valid_ex), .fpu_done(fpu_done), .br_flush(br_flush),
    .PC_Wr(PC_Wr_b), .IF_ID_Wr(IF_ID_Wr_b), .ID_EX_Wr(ID_EX_Wr_b),
    .IF_ID_Flush(IF_ID_Flush_b), .ID_EX_Flush(ID_EX_Flush_b), .EX_MEM_Bubble(EX_MEM_Bubble_b),
    .fpu_busy(fpu_busy_b), .fpu_err(fpu_err_b), .stall_cnt(stall_cnt_b));

  assign ctl_a = {PC_Wr_a, IF_ID_Wr_a, ID_EX_Wr_a, IF_ID_Flush_a, ID_EX_Flush_a, EX_MEM_Bubble_a};
  assign ctl_b = {PC_Wr_b, IF_ID_Wr_b, ID_EX_Wr_b, IF_ID_Flush_b, ID_EX_Flush_b, EX_MEM_Bubble_b};

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u2;
    logic [6:0] opid;
    logic [4:0] rd;
    logic       memrd, regwr;
    logic [6:0] opex;
    logic       vld, done, br;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input string n, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u2, input logic [6:0] opid, input logic [4:0] rd,
                              input logic memrd, input logic regwr, input logic [6:0] opex,
                              input logic vld, input logic done, input logic br,
                              input logic [5:0] exp);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u2 = u2; v.opid = opid; v.rd = rd;
    v.memrd = memrd; v.regwr = regwr; v.opex = opex; v.vld = vld; v.done = done;
    v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rs1_id = v.rs1; rs2_id = v.rs2; uses_rs2_id = v.u2; opcode_id = v.opid;
    rd_ex = v.rd; MemRd_ex = v.memrd; RegWr_ex = v.regwr; opcode_ex = v.opex;
    valid_ex = v.vld; fpu_done = v.done; br_flush = v.br;
  endtask

  task automatic idle();
    rs1_id = 5'd0; rs2_id = 5'd0; uses_rs2_id = 1'b0; opcode_id = 7'd0; rd_ex = 5'd0;
    MemRd_ex = 1'b0; RegWr_ex = 1'b0; opcode_ex = 7'd0; valid_ex = 1'b0;
    fpu_done = 1'b0; br_flush = 1'b0;
  endtask

  task automatic load_use_in();
    idle();
    rs1_id = 5'd5; opcode_id = OP_ADD; rd_ex = 5'd5; MemRd_ex = 1'b1; RegWr_ex = 1'b1;
    opcode_ex = OP_LW; valid_ex = 1'b1;
  endtask

  task automatic fp_in();
    idle();
    opcode_ex = OP_FP; valid_ex = 1'b1;
  endtask

  // Two reset cycles; outputs must be forced even with a hazard on the inputs.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    load_use_in();
    #1;
    chk("rst_ctl_b", 32'(ctl_b), 32'(RUNV));
    chk("rst_cnt_b", stall_cnt_b, 32'd0);
    chk("rst_busy_err_b", {fpu_busy_b, fpu_err_b}, 32'd0);
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tbl[0]  = mk("no_hazard",   5'd1, 5'd2, 1'b1, OP_ADD, 5'd5, 1'b1, 1'b1, OP_LW,  1'b1, 1'b0, 1'b0, RUNV);
    tbl[1]  = mk("lu_rs1",      5'd5, 5'd2, 1'b1, OP_ADD, 5'd5, 1'b1, 1'b1, OP_LW,  1'b1, 1'b0, 1'b0, LU);
    tbl[2]  = mk("lu_rs2",      5'd1, 5'd5, 1'b1, OP_ADD, 5'd5, 1'b1, 1'b1, OP_LW,  1'b1, 1'b0, 1'b0, LU);
    tbl[3]  = mk("rs2_unused",  5'd1, 5'd5, 1'b0, OP_ADD, 5'd5, 1'b1, 1'b1, OP_LW,  1'b1, 1'b0, 1'b0, RUNV);
    tbl[4]  = mk("rd_x0",       5'd0, 5'd0, 1'b1, OP_ADD, 5'd0, 1'b1, 1'b1, OP_LW,  1'b1, 1'b0, 1'b0, RUNV);
    tbl[5]  = mk("not_load",    5'd5, 5'd2, 1'b1, OP_ADD, 5'd5, 1'b0, 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, RUNV);
    tbl[6]  = mk("no_regwr",    5'd5, 5'd2, 1'b1, OP_ADD, 5'd5, 1'b1, 1'b0, OP_LW,  1'b1, 1'b0, 1'b0, RUNV);
    tbl[7]  = mk("id_is_fp",    5'd5, 5'd2, 1'b1, OP_FP,  5'd5, 1'b1, 1'b1, OP_LW,  1'b1, 1'b0, 1'b0, RUNV);
    tbl[8]  = mk("br_over_lu",  5'd5, 5'd2, 1'b1, OP_ADD, 5'd5, 1'b1, 1'b1, OP_LW,  1'b1, 1'b0, 1'b1, BRF);
    tbl[9]  = mk("br_over_fpu", 5'd0, 5'd0, 1'b0, OP_ADD, 5'd0, 1'b0, 1'b0, OP_FP,  1'b1, 1'b0, 1'b1, BRF);
    tbl[10] = mk("fp_invalid",  5'd0, 5'd0, 1'b0, OP_ADD, 5'd0, 1'b0, 1'b0, OP_FP,  1'b0, 1'b0, 1'b0, RUNV);
    tbl[11] = mk("fp_done_now", 5'd0, 5'd0, 1'b0, OP_ADD, 5'd0, 1'b0, 1'b0, OP_FP,  1'b1, 1'b1, 1'b0, RUNV);

    do_reset();

    // Table of single-cycle RUN decisions on the done-signalled instance.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk(tbl[i].name, 32'(ctl_b), 32'(tbl[i].exp));
    end
    @(negedge clk);
    idle();
    #1;
    chk("tbl_stall_cnt", stall_cnt_b, 32'd2);

    // Load-use: one bubble, then free-running.
    do_reset();
    @(negedge clk); load_use_in(); #1;
    chk("lu_seq_stall", 32'(ctl_b), 32'(LU));
    @(negedge clk); idle(); #1;
    chk("lu_seq_release", 32'(ctl_b), 32'(RUNV));
    chk("lu_seq_cnt", stall_cnt_b, 32'd1);

    // Fixed latency 4: three stall cycles, two in FPW hold, exit with redirect.
    do_reset();
    @(negedge clk); fp_in(); #1;
    chk("lat_c0", 32'(ctl_a), 32'(STL));
    chk("lat_c0_busy", 32'(fpu_busy_a), 32'd0);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk); #1;
      chk("lat_hold", 32'(ctl_a), 32'(STL));
      chk("lat_hold_busy", 32'(fpu_busy_a), 32'd1);
    end
    @(negedge clk); br_flush = 1'b1; #1;
    chk("lat_exit_br", 32'(ctl_a), 32'(BRF));
    chk("lat_exit_busy", 32'(fpu_busy_a), 32'd0);
    @(negedge clk); idle(); #1;
    chk("lat_after", 32'(ctl_a), 32'(RUNV));
    chk("lat_cnt", 32'(stall_cnt_a), 32'd3);

    // Done-signalled: redirect during hold is deferred to the done cycle.
    do_reset();
    @(negedge clk); fp_in(); #1;
    chk("done_c0", 32'(ctl_b), 32'(STL));
    @(negedge clk); #1;
    chk("done_c1", 32'(ctl_b), 32'(STL));
    chk("done_c1_busy", 32'(fpu_busy_b), 32'd1);
    @(negedge clk); br_flush = 1'b1; #1;
    chk("done_c2_br_held", 32'(ctl_b), 32'(STL));
    @(negedge clk); br_flush = 1'b0; #1;
    chk("done_c3", 32'(ctl_b), 32'(STL));
    @(negedge clk); #1;
    chk("done_c4", 32'(ctl_b), 32'(STL));
    @(negedge clk); fpu_done = 1'b1; #1;
    chk("done_exit_flush", 32'(ctl_b), 32'(BRF));
    chk("done_exit_busy", 32'(fpu_busy_b), 32'd0);
    @(negedge clk); idle(); #1;
    chk("done_after", 32'(ctl_b), 32'(RUNV));
    chk("done_cnt", stall_cnt_b, 32'd5);

    // Timeout after 8 FPW cycles: result discarded, sticky error.
    do_reset();
    @(negedge clk); fp_in(); #1;
    chk("to_c0", 32'(ctl_b), 32'(STL));
    for (int c = 1; c < 8; c++) begin
      @(negedge clk); #1;
      chk("to_hold", 32'(ctl_b), 32'(STL));
    end
    @(negedge clk); #1;
    chk("to_exit", 32'(ctl_b), 32'(TOX));
    chk("to_exit_busy", 32'(fpu_busy_b), 32'd0);
    @(negedge clk); idle(); #1;
    chk("to_after", 32'(ctl_b), 32'(RUNV));
    chk("to_err_set", 32'(fpu_err_b), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("to_err_sticky", 32'(fpu_err_b), 32'd1);

    // Reset in the third FPW cycle, with a pending redirect and error set.
    @(negedge clk); fp_in(); #1;
    chk("rmid_c0", 32'(ctl_b), 32'(STL));
    @(negedge clk); br_flush = 1'b1; #1;
    chk("rmid_fpw1", 32'(ctl_b), 32'(STL));
    @(negedge clk); br_flush = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk("rmid_forced", 32'(ctl_b), 32'(RUNV));
    @(negedge clk); rst = 1'b0; idle(); #1;
    chk("rmid_ctl", 32'(ctl_b), 32'(RUNV));
    chk("rmid_busy", 32'(fpu_busy_b), 32'd0);
    chk("rmid_cnt", stall_cnt_b, 32'd0);
    chk("rmid_err", 32'(fpu_err_b), 32'd0);

    // Stall counter saturation on the 4-bit instance.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); load_use_in();
    end
    @(negedge clk); idle(); #1;
    chk("sat_cnt_a", 32'(stall_cnt_a), 32'd15);
    chk("sat_cnt_b", stall_cnt_b, 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
